ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
//  AHB3-Lite responder: word-organised SRAM behind one HSEL. Accepts master
//  transfers (NONSEQ/SEQ, byte/half/word), inserts configurable wait states,
//  returns two-cycle ERROR for illegal accesses. Reference slave/bus-model for
//  the AHB3 slave bench; sits on the same ahb_intf signals as the DUT.
// PARAMETERS
//  HADDR_SIZE   8   address width (bits)
//  HDATA_SIZE   32  data width (bits); fixed at 32
//  MEM_DEPTH    32  number of 32-bit words; valid bytes 0..MEM_DEPTH*4-1
//  WAIT_STATES  0   HREADYOUT-low cycles per data phase (0..15)
// PORTS
//  HCLK       in   1   bus clock, all logic on rising edge
//  HRESETn    in   1   asynchronous, active-low reset
//  HSEL       in   1   slave select
//  HADDR      in   8   byte address (address phase)
//  HWDATA     in   32  write data (data phase)
//  HRDATA     out  32  read data (data phase)
//  HWRITE     in   1   1=write, 0=read
//  HSIZE      in   3   0=byte 1=half 2=word; >2 illegal
//  HBURST     in   3   ignored (bursts = NONSEQ+SEQ beats)
//  HPROT      in   4   used only with AHB_SLAVE_PROT_EN
//  HTRANS     in   2   0 IDLE,1 BUSY,2 NONSEQ,3 SEQ
//  HREADY     in   1   bus ready (previous data phase done)
//  HREADYOUT  out  1   this slave's data-phase ready
//  HRESP      out  1   0=OKAY 1=ERROR
// BEHAVIOUR
//  - Reset (async, any cycle incl. mid-wait/mid-error): FSM->IDLE, HREADYOUT=1,
//    HRESP=0, HRDATA=0, wait counter=0, latched addr-phase regs cleared; pending
//    write discarded. SRAM contents not reset.
//  - Accept: HSEL & HREADY & HTRANS[1] at rising edge -> latch HADDR,HWRITE,
//    HSIZE(,HPROT). IDLE/BUSY or HSEL=0: no transfer, OKAY, zero wait.
//  - Illegal if: HADDR >= MEM_DEPTH*4, HSIZE>2, misaligned (half: HADDR[0]!=0;
//    word: HADDR[1:0]!=0).
//  - FSM: IDLE (HREADYOUT=1,HRESP=0) | WAIT | ERR1 | ERR2.
//    IDLE: legal accept & WAIT_STATES>0 -> WAIT (cnt=WAIT_STATES); legal &
//      WAIT_STATES=0 -> stay IDLE, data phase completes next cycle; illegal -> ERR1.
//    WAIT: HREADYOUT=0; cnt-- each edge; at cnt==1 -> IDLE (data phase ends
//      with HREADYOUT=1). No new accept while HREADYOUT=0 (HREADY low).
//    ERR1: HREADYOUT=0,HRESP=1 -> ERR2. ERR2: HREADYOUT=1,HRESP=1 -> IDLE,
//      accept evaluated normally at ERR2 edge. Errors skip wait states.
//  - Write: committed at the edge ending the data phase (HREADYOUT=1) using
//    HWDATA lanes: byte lane HADDR[1:0], half lanes {HADDR[1],x}, word all.
//    Other bytes preserved. Errored writes never modify SRAM.
//  - Read: HRDATA = full word mem[addr>>2] during read data phase (master
//    selects lanes); 0 otherwise and during ERR1/ERR2. Read issued right after
//    a write to same word sees new data (write commits before read data phase).
//  - Back-to-back pipelined transfers at WAIT_STATES=0: one per cycle.
// CONFIGURATION
//  AHB_SLAVE_PROT_EN defined: write with HPROT[1]=0 (user) to upper half
//   (addr >= MEM_DEPTH*2) is illegal -> ERR1/ERR2, no write; reads unaffected.
//  Undefined: HPROT ignored, no protection errors.
// TESTING
//  1 WS=0: write word 0x10=0xDEADBEEF, read 0x10 -> HRDATA=0xDEADBEEF, HRESP=0,
//    no HREADYOUT low.
//  2 Byte write 0x12=0xAA (HWDATA=0x00AA0000,HSIZE=0) over 1 -> read 0x10
//    = 0xDEAABEEF.
//  3 WS=3: read 0x04 -> HREADYOUT low exactly 3 cycles, data valid 4th cycle.
//  4 Read 0x80 (out of range) / word at 0x02 -> HREADYOUT 0,1 with HRESP 1,1;
//    then IDLE: HRESP=0; SRAM unchanged.
//  5 Assert HRESETn=0 during WAIT cnt=2 -> immediately HREADYOUT=1, HRESP=0,
//    HRDATA=0; pending write not committed.
//  6 PROT_EN: user write 0x40=0x1 -> ERROR, readback old; privileged (HPROT=4'b0011)
//    -> OKAY, readback 0x1.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB3-Lite word-organised SRAM responder with configurable wait states and two-cycle ERROR.
// Optional write protection of the upper half of the SRAM: define AHB_SLAVE_PROT_EN.
module ahb_sram_slave #(
    parameter int unsigned HADDR_SIZE  = 8,
    parameter int unsigned HDATA_SIZE  = 32,
    parameter int unsigned MEM_DEPTH   = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned MEM_BYTES = MEM_DEPTH * 4;
    localparam logic [3:0]  WS_LOAD   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic                  r_dvalid;
    logic                  r_write;
    logic [1:0]            r_size;
    logic [1:0]            r_lane;
    logic [IDX_W-1:0]      r_widx;
    logic [3:0]            r_cnt;
    logic [HDATA_SIZE-1:0] r_mem [MEM_DEPTH];

    logic       w_take;
    logic       w_illegal;
    logic       w_we;
    logic [3:0] w_be;
    logic       w_unused;

    assign w_unused = ^{HBURST, HPROT};

    // Only IDLE and ERR2 drive HREADYOUT high, so only they can take a new address phase.
    assign w_take = HSEL & HREADY & HTRANS[1] & ((r_state == StIdle) | (r_state == StErr2));

    always_comb begin
        w_illegal = 1'b0;
        if (32'(HADDR) >= MEM_BYTES)                   w_illegal = 1'b1;
        if (HSIZE > 3'd2)                              w_illegal = 1'b1;
        if ((HSIZE == 3'd1) && HADDR[0])               w_illegal = 1'b1;
        if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))  w_illegal = 1'b1;
`ifdef AHB_SLAVE_PROT_EN
        if (HWRITE && !HPROT[1] && (32'(HADDR) >= MEM_DEPTH * 2)) w_illegal = 1'b1;
`endif
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= StIdle;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StErr2: begin
                if (!w_take)         w_state_next = StIdle;
                else if (w_illegal)  w_state_next = StErr1;
                else if (WAIT_STATES > 0) w_state_next = StWait;
                else                 w_state_next = StIdle;
            end
            StWait:  if (r_cnt == 4'd1) w_state_next = StIdle;
            StErr1:  w_state_next = StErr2;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        unique case (r_state)
            StWait:  HREADYOUT = 1'b0;
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            StErr2:  HRESP = 1'b1;
            default: ;
        endcase
        if (r_dvalid && !r_write) HRDATA = r_mem[r_widx];
    end

    // r_dvalid marks a legal data phase in progress; errored transfers never set it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dvalid <= 1'b0;
            r_write  <= 1'b0;
            r_size   <= 2'd0;
            r_lane   <= 2'd0;
            r_widx   <= '0;
            r_cnt    <= 4'd0;
        end else begin
            if (w_take) begin
                r_dvalid <= ~w_illegal;
                r_write  <= HWRITE;
                r_size   <= HSIZE[1:0];
                r_lane   <= HADDR[1:0];
                r_widx   <= HADDR[IDX_W+1:2];
            end else if (r_state == StIdle) begin
                r_dvalid <= 1'b0;
            end
            if (w_take && !w_illegal) r_cnt <= WS_LOAD;
            else if (r_state == StWait) r_cnt <= r_cnt - 4'd1;
        end
    end

    always_comb begin
        w_be = 4'b0000;
        unique case (r_size)
            2'd0:    w_be[r_lane] = 1'b1;
            2'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Commit on the edge that ends the data phase, so a following read sees the new word.
    assign w_we = r_dvalid & r_write & (r_state == StIdle);

    always_ff @(posedge HCLK) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[r_widx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: two instances (0 and 3 wait states) on one master,
// checked every cycle against a byte-level SRAM model plus literal spot checks.
module tb_ahb_sram_slave;

    localparam int MEM_BYTES = 128;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  prot;
    } xfer_t;

    logic        clk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic        tgt;
    logic        hwrite;
    logic [7:0]  haddr;
    logic [31:0] hwdata;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hrdata0, hrdata3;
    logic        hreadyout0, hreadyout3, hresp0, hresp3;
    logic        hready, hsel0, hsel3;
    logic [31:0] t_rdata;
    logic        t_rdy, t_resp, o_rdy, o_resp;

    always #5 clk = ~clk;

    assign hsel0   = hsel & ~tgt;
    assign hsel3   = hsel & tgt;
    assign hready  = tgt ? hreadyout3 : hreadyout0;
    assign t_rdy   = hready;
    assign t_resp  = tgt ? hresp3 : hresp0;
    assign t_rdata = tgt ? hrdata3 : hrdata0;
    assign o_rdy   = tgt ? hreadyout0 : hreadyout3;
    assign o_resp  = tgt ? hresp0 : hresp3;

    ahb_sram_slave #(.HADDR_SIZE(8), .HDATA_SIZE(32), .MEM_DEPTH(32), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel0), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(hrdata0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HTRANS(htrans), .HREADY(hready), .HREADYOUT(hreadyout0), .HRESP(hresp0)
    );

    ahb_sram_slave #(.HADDR_SIZE(8), .HDATA_SIZE(32), .MEM_DEPTH(32), .WAIT_STATES(3)) u_dut3 (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel3), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(hrdata3), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HTRANS(htrans), .HREADY(hready), .HREADYOUT(hreadyout3), .HRESP(hresp3)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  mdl [2][MEM_BYTES];
    bit          known [2][MEM_BYTES];
    xfer_t       q[$];
    bit          dp_active = 1'b0;
    int          waits = 0;
    int          err_seen = 0;
    logic [31:0] mon_rdata = 32'd0;
    int          mon_waits = 0;
    int          mon_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit legal_of(input xfer_t it);
        if (int'(it.addr) >= MEM_BYTES) return 1'b0;
        if (it.size > 3'd2) return 1'b0;
        if (it.size == 3'd1 && (it.addr % 2) != 0) return 1'b0;
        if (it.size == 3'd2 && (it.addr % 4) != 0) return 1'b0;
`ifdef AHB_SLAVE_PROT_EN
        if (it.wr && !it.prot[1] && int'(it.addr) >= MEM_BYTES / 2) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic complete_xfer(input xfer_t it);
        int          t;
        int          base;
        int          b;
        bit          all_known;
        logic [31:0] exp_word;
        t         = tgt ? 1 : 0;
        mon_rdata = t_rdata;
        mon_waits = waits;
        mon_err   = err_seen + (t_resp ? 1 : 0);
        if (!legal_of(it)) begin
            chk("err_resp", 32'(t_resp), 32'd1);
            chk("err_first_cycle", 32'(err_seen), 32'd1);
            chk("err_no_waits", 32'(waits), 32'd0);
            chk("err_rdata", t_rdata, 32'd0);
        end else begin
            chk("ok_resp", 32'(t_resp), 32'd0);
            chk("ok_no_err_cycle", 32'(err_seen), 32'd0);
            chk("ok_waits", 32'(waits), tgt ? 32'd3 : 32'd0);
            if (it.wr) begin
                for (int i = 0; i < (1 << it.size); i++) begin
                    b = int'(it.addr) + i;
                    mdl[t][b]   = it.wdata[8*(b%4) +: 8];
                    known[t][b] = 1'b1;
                end
            end else begin
                base      = int'(it.addr) - int'(it.addr) % 4;
                all_known = 1'b1;
                exp_word  = 32'd0;
                for (int i = 0; i < 4; i++) begin
                    exp_word[8*i +: 8] = mdl[t][base+i];
                    all_known          = all_known & known[t][base+i];
                end
                if (all_known) chk("read_data", t_rdata, exp_word);
            end
        end
    endtask

    // Bus monitor: follows each accepted transfer through its data phase.
    always @(negedge clk) begin
        if (!hresetn) begin
            dp_active = 1'b0;
            q.delete();
        end else begin
            if (dp_active) begin
                if (!t_rdy) begin
                    if (t_resp) begin
                        err_seen++;
                        chk("err1_rdata", t_rdata, 32'd0);
                    end else begin
                        waits++;
                    end
                    if (waits + err_seen > 20) begin
                        chk("dphase_len", 32'(waits + err_seen), tgt ? 32'd3 : 32'd0);
                        dp_active = 1'b0;
                        q.delete();
                    end
                end else begin
                    if (q.size() == 0) chk("expected_xfer", 32'(q.size()), 32'd1);
                    else complete_xfer(q.pop_front());
                    dp_active = 1'b0;
                end
            end else begin
                chk("idle_ready", 32'(t_rdy), 32'd1);
                chk("idle_resp", 32'(t_resp), 32'd0);
                chk("idle_rdata", t_rdata, 32'd0);
            end
            chk("other_ready", 32'(o_rdy), 32'd1);
            chk("other_resp", 32'(o_resp), 32'd0);
            if (hsel && hready && htrans[1]) begin
                dp_active = 1'b1;
                waits     = 0;
                err_seen  = 0;
            end
        end
    end

    task automatic issue(input bit wr, input logic [7:0] a, input logic [2:0] sz,
                         input logic [31:0] wd, input logic [3:0] pr);
        xfer_t it;
        int    n = 0;
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
        hprot  = pr;
        @(negedge clk);
        while (!hready && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("accept_ready", 32'(hready), 32'd1);
        it.wr = wr; it.addr = a; it.size = sz; it.wdata = wd; it.prot = pr;
        q.push_back(it);
        @(posedge clk);
        #1;
        hwdata = wd;
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr  = 8'd0;
        hsize  = 3'd0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || dp_active) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", 32'(q.size()), 32'd0);
    endtask

    localparam logic [3:0] PRIV = 4'b0011;
    localparam logic [3:0] USER = 4'b0001;

    initial begin
        hresetn = 1'b0; hsel = 1'b0; tgt = 1'b0; hwrite = 1'b0; haddr = 8'd0;
        hwdata = 32'd0; hsize = 3'd0; hburst = 3'd0; hprot = PRIV; htrans = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready0", 32'(hreadyout0), 32'd1);
        chk("rst_resp0", 32'(hresp0), 32'd0);
        chk("rst_rdata0", hrdata0, 32'd0);
        chk("rst_ready3", 32'(hreadyout3), 32'd1);
        chk("rst_resp3", 32'(hresp3), 32'd0);
        chk("rst_rdata3", hrdata3, 32'd0);
        hresetn = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait word write then read
        issue(1, 8'h10, 3'd2, 32'hDEADBEEF, PRIV);
        issue(0, 8'h10, 3'd2, 32'd0, PRIV);
        drain();
        chk("t1_rdata", mon_rdata, 32'hDEADBEEF);
        chk("t1_waits", 32'(mon_waits), 32'd0);

        // Byte and halfword merges
        issue(1, 8'h12, 3'd0, 32'h00AA0000, PRIV);
        issue(0, 8'h10, 3'd2, 32'd0, PRIV);
        drain();
        chk("t2_byte_merge", mon_rdata, 32'hDEAABEEF);
        issue(1, 8'h0C, 3'd2, 32'h11223344, PRIV);
        issue(1, 8'h0E, 3'd1, 32'hBEEF0000, PRIV);
        issue(0, 8'h0C, 3'd2, 32'd0, PRIV);
        drain();
        chk("t2_half_merge", mon_rdata, 32'hBEEF3344);

        // BUSY and unselected NONSEQ are not transfers
        hsel = 1'b1; htrans = 2'b01; haddr = 8'h80;
        repeat (2) @(posedge clk);
        #1;
        hsel = 1'b0; htrans = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        htrans = 2'b00; haddr = 8'd0;

        // Errors, including a legal accept on the ERR2 edge
        issue(0, 8'h80, 3'd2, 32'd0, PRIV);
        drain();
        chk("t4_err_cycles", 32'(mon_err), 32'd2);
        issue(0, 8'h80, 3'd2, 32'd0, PRIV);
        issue(0, 8'h10, 3'd2, 32'd0, PRIV);
        issue(1, 8'h11, 3'd2, 32'h55555555, PRIV);
        issue(0, 8'h10, 3'd3, 32'd0, PRIV);
        issue(0, 8'h10, 3'd2, 32'd0, PRIV);
        drain();
        chk("t4_sram_unchanged", mon_rdata, 32'hDEAABEEF);

        // Back-to-back pipelined traffic
        issue(1, 8'h20, 3'd2, 32'hA5A5A5A5, PRIV);
        issue(0, 8'h20, 3'd2, 32'd0, PRIV);
        issue(1, 8'h22, 3'd1, 32'h12340000, PRIV);
        issue(0, 8'h20, 3'd2, 32'd0, PRIV);
        issue(1, 8'h21, 3'd0, 32'h00007700, PRIV);
        issue(0, 8'h20, 3'd2, 32'd0, PRIV);
        drain();
        chk("pipe_final", mon_rdata, 32'h123477A5);

        // Upper-half write protection
        issue(1, 8'h40, 3'd2, 32'hFFFF0000, PRIV);
        issue(1, 8'h40, 3'd2, 32'h00000001, USER);
        drain();
`ifdef AHB_SLAVE_PROT_EN
        chk("prot_user_err", 32'(mon_err), 32'd2);
`else
        chk("prot_user_ok", 32'(mon_err), 32'd0);
`endif
        issue(0, 8'h40, 3'd2, 32'd0, USER);
        drain();
`ifdef AHB_SLAVE_PROT_EN
        chk("prot_user_read", mon_rdata, 32'hFFFF0000);
`else
        chk("prot_user_read", mon_rdata, 32'h00000001);
`endif
        issue(1, 8'h40, 3'd2, 32'h00000001, PRIV);
        issue(0, 8'h40, 3'd2, 32'd0, USER);
        drain();
        chk("prot_priv_read", mon_rdata, 32'h00000001);

        // Three wait states
        @(posedge clk);
        #1;
        tgt = 1'b1;
        issue(1, 8'h04, 3'd2, 32'h0BADF00D, PRIV);
        issue(0, 8'h04, 3'd2, 32'd0, PRIV);
        drain();
        chk("ws3_waits", 32'(mon_waits), 32'd3);
        chk("ws3_rdata", mon_rdata, 32'h0BADF00D);
        issue(0, 8'h02, 3'd2, 32'd0, PRIV);
        drain();
        chk("ws3_err_cycles", 32'(mon_err), 32'd2);
        chk("ws3_err_waits", 32'(mon_waits), 32'd0);
        issue(0, 8'h80, 3'd2, 32'd0, PRIV);
        issue(0, 8'h04, 3'd2, 32'd0, PRIV);
        drain();
        chk("ws3_after_err", mon_rdata, 32'h0BADF00D);

        // Reset in the middle of a waited write
        issue(1, 8'h08, 3'd2, 32'hCAFEF00D, PRIV);
        drain();
        issue(1, 8'h08, 3'd2, 32'h12345678, PRIV);
        @(posedge clk);
        #2;
        hresetn = 1'b0;
        #1;
        chk("midrst_ready", 32'(hreadyout3), 32'd1);
        chk("midrst_resp", 32'(hresp3), 32'd0);
        chk("midrst_rdata", hrdata3, 32'd0);
        @(posedge clk);
        #1;
        hresetn = 1'b1;
        @(posedge clk);
        #1;
        issue(0, 8'h08, 3'd2, 32'd0, PRIV);
        drain();
        chk("midrst_no_commit", mon_rdata, 32'hCAFEF00D);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
